// File: rtl/onehot_seq_pkg.sv
// Shared types and helpers for the one-hot select sequencer.
// Pure declarations; no timing or flow-control behaviour of its own.
package onehot_seq_pkg;

    localparam int NCODES = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIND  = 3'd1,
        ST_OFFER = 3'd2,
        ST_DWELL = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic logic [NCODES-1:0] clear_rsvd(input logic [NCODES-1:0] mask,
                                                     input logic [SEL_W-1:0]  rsvd);
        logic [NCODES-1:0] res;
        res       = mask;
        res[rsvd] = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/onehot_next_code.sv
// Priority search for the lowest enabled code at or above idx_i; purely combinational.
// Zero latency, no flow control.
module onehot_next_code
    import onehot_seq_pkg::*;
(
    input  logic [NCODES-1:0] mask_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic              found_o,
    output logic [SEL_W-1:0]  code_o
);

    // Scan downwards so the lowest qualifying code is the last one written.
    always_comb begin
        found_o = 1'b0;
        code_o  = '0;
        for (int i = NCODES - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(idx_i))) begin
                found_o = 1'b1;
                code_o  = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_sel_sequencer.sv
// Sweeps enabled select codes in ascending order, each offered via valid/ready then held DWELL cycles.
// sel_valid_o appears two cycles after start; a stalled offer holds sel_o/sel_valid_o until sel_ready_i.
module onehot_sel_sequencer
    import onehot_seq_pkg::*;
#(
    parameter int               DWELL     = 4,
    parameter logic [SEL_W-1:0] RSVD_CODE = 3'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [NCODES-1:0] mask_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              sel_valid_o,
    input  logic              sel_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int               CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [NCODES-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              past_end_q, past_end_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hit_idx, hit_zero;
    logic [SEL_W-1:0]  code_idx, code_zero;

    onehot_next_code u_from_idx (
        .mask_i  (mask_q),
        .idx_i   (idx_q),
        .found_o (hit_idx),
        .code_o  (code_idx)
    );

    onehot_next_code u_from_zero (
        .mask_i  (mask_q),
        .idx_i   ({SEL_W{1'b0}}),
        .found_o (hit_zero),
        .code_o  (code_zero)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        past_end_d = past_end_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d     = clear_rsvd(mask_i, RSVD_CODE);
                    idx_d      = '0;
                    past_end_d = 1'b0;
                    state_d    = ST_FIND;
                end
            end
            ST_FIND: begin
                // Once the top was crossed only a loop restart from code 0 may continue.
                if (hit_idx && !past_end_q) begin
                    sel_d   = code_idx;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end else if (loop_i && hit_zero) begin
                    sel_d      = code_zero;
                    valid_d    = 1'b1;
                    past_end_d = 1'b0;
                    state_d    = ST_OFFER;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_OFFER: begin
                if (sel_ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    idx_d      = sel_q + 1'b1;
                    past_end_d = (sel_q == SEL_W'(NCODES - 1));
                    state_d    = ST_FIND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop_i) begin
            state_d = ST_IDLE;
            mask_d  = mask_q;
            valid_d = 1'b0;
            sel_d   = sel_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            past_end_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            past_end_q <= past_end_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_onehot_sel_sequencer.sv
// Bench for onehot_sel_sequencer: table vectors, random sweeps against a code-list model,
// plus hand-written abort and asynchronous-reset sequences.
module tb_onehot_sel_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, stop_i, loop_i, sel_ready_i;
    logic [7:0] mask_i;
    logic [2:0] sel_o;
    logic       sel_valid_o, busy_o, done_o;

    always #5 clk = ~clk;

    onehot_sel_sequencer #(.DWELL(DWELL), .RSVD_CODE(3'd1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .loop_i      (loop_i),
        .mask_i      (mask_i),
        .sel_o       (sel_o),
        .sel_valid_o (sel_valid_o),
        .sel_ready_i (sel_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observations of one sweep
    logic [2:0] got_codes[$];
    int         hs_t[$];
    int         rise_t[$];
    int         done_cnt, done_t, inv_errs, stall_errs;
    bit         timed_out;

    // Expected code list: ascending enabled codes (never 1); in loop mode the list repeats
    // until loop is dropped, then continues only above the last issued code.
    logic [2:0] exp_codes[$];

    task automatic build_expected(input logic [7:0] m, input int loop_hs);
        int base[$];
        exp_codes.delete();
        for (int c = 0; c < 8; c++)
            if (m[c] && c != 1) base.push_back(c);
        if (base.size() == 0) return;
        if (loop_hs == 0) begin
            foreach (base[i]) exp_codes.push_back(3'(base[i]));
            return;
        end
        while (exp_codes.size() < loop_hs)
            foreach (base[i])
                if (exp_codes.size() < loop_hs) exp_codes.push_back(3'(base[i]));
        foreach (base[j])
            if (base[j] > int'(exp_codes[$])) exp_codes.push_back(3'(base[j]));
    endtask

    // rmode: 0 ready tied high, 1 random ready, 2 ready low for the first 3 cycles of each offer
    task automatic run_sweep(input logic [7:0] m, input int loop_hs, input int rmode);
        int         t;
        int         vis;
        bit         prev_v, prev_stall;
        logic [2:0] prev_sel;
        got_codes.delete(); hs_t.delete(); rise_t.delete();
        done_cnt = 0; done_t = -1; inv_errs = 0; stall_errs = 0; timed_out = 0;
        mask_i = m; loop_i = (loop_hs != 0); start_i = 1'b1; sel_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        mask_i  = ~m;
        prev_v = 0; prev_stall = 0; prev_sel = '0; vis = 0; t = 0;
        while (t < 600) begin
            if (sel_valid_o && !prev_v) rise_t.push_back(t);
            if (prev_stall && (!sel_valid_o || sel_o != prev_sel)) stall_errs++;
            if (sel_valid_o && (sel_o == 3'd1 || !m[sel_o])) inv_errs++;
            if (done_o) begin
                done_cnt++;
                done_t = t;
            end
            if (!busy_o) break;
            vis = sel_valid_o ? vis + 1 : 0;
            case (rmode)
                1:       sel_ready_i = ($urandom_range(0, 2) != 0);
                2:       sel_ready_i = (vis > 3);
                default: sel_ready_i = 1'b1;
            endcase
            if (sel_valid_o && sel_ready_i) begin
                got_codes.push_back(sel_o);
                hs_t.push_back(t + 1);
                if (loop_hs != 0 && got_codes.size() >= loop_hs) loop_i = 1'b0;
            end
            prev_v     = sel_valid_o;
            prev_stall = sel_valid_o && !sel_ready_i;
            prev_sel   = sel_o;
            tick();
            t++;
        end
        timed_out   = (t >= 600);
        sel_ready_i = 1'b1;
        loop_i      = 1'b0;
    endtask

    task automatic check_sweep(input logic [7:0] m, input int loop_hs);
        build_expected(m, loop_hs);
        check("sweep_timeout", int'(timed_out), 0);
        check("code_count", got_codes.size(), exp_codes.size());
        for (int i = 0; i < exp_codes.size() && i < got_codes.size(); i++)
            check("code_value", int'(got_codes[i]), int'(exp_codes[i]));
        check("done_pulses", done_cnt, 1);
        check("done_time", done_t, (hs_t.size() == 0) ? 1 : hs_t[$] + DWELL + 1);
        check("rise_count", rise_t.size(), hs_t.size());
        if (rise_t.size() > 0) check("first_valid_time", rise_t[0], 1);
        for (int i = 1; i < rise_t.size() && i <= hs_t.size(); i++)
            check("next_code_time", rise_t[i], hs_t[i-1] + DWELL + 1);
        check("valid_code_invariant", inv_errs, 0);
        check("stall_stability", stall_errs, 0);
        check("busy_after_done", int'(busy_o), 0);
        if (exp_codes.size() > 0) check("sel_retained", int'(sel_o), int'(exp_codes[$]));
    endtask

    typedef struct {
        logic [7:0] mask;
        int         loop_hs;
        int         rmode;
        int         exp_n;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dsum, n;
        logic [7:0] rm;
        int rl;

        vecs[0] = '{8'hFF, 0, 0, 7, 0, 7};
        vecs[1] = '{8'h86, 0, 2, 2, 2, 7};
        vecs[2] = '{8'h02, 0, 0, 0, 0, 0};
        vecs[3] = '{8'h02, 3, 0, 0, 0, 0};
        vecs[4] = '{8'h11, 4, 0, 4, 0, 4};
        vecs[5] = '{8'h80, 0, 1, 1, 7, 7};
        vecs[6] = '{8'h0B, 0, 0, 2, 0, 3};
        vecs[7] = '{8'hA0, 5, 1, 6, 5, 7};

        rst_n = 1'b0; start_i = 0; stop_i = 0; loop_i = 0; sel_ready_i = 1; mask_i = '0;
        #1;
        check("reset_sel", int'(sel_o), 0);
        check("reset_valid", int'(sel_valid_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[v]) begin
            run_sweep(vecs[v].mask, vecs[v].loop_hs, vecs[v].rmode);
            check_sweep(vecs[v].mask, vecs[v].loop_hs);
            check("table_count", got_codes.size(), vecs[v].exp_n);
            if (vecs[v].exp_n > 0 && got_codes.size() > 0) begin
                check("table_first", int'(got_codes[0]), vecs[v].exp_first);
                check("table_last", int'(got_codes[$]), vecs[v].exp_last);
            end
            tick();
        end

        for (int r = 0; r < 8; r++) begin
            rm = 8'($urandom);
            rl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
            run_sweep(rm, rl, int'($urandom_range(0, 2)));
            check_sweep(rm, rl);
            tick();
        end

        // Abort during the dwell of code 3
        mask_i = 8'hFF; start_i = 1'b1; sel_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (n < 100 && !(sel_valid_o && sel_o == 3'd3)) begin
            tick();
            n++;
        end
        check("abort_reached_code3", int'(sel_valid_o && sel_o == 3'd3), 1);
        tick();
        tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("abort_valid", int'(sel_valid_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_sel", int'(sel_o), 3);
        check("abort_done", int'(done_o), 0);
        dsum = 0;
        repeat (8) begin
            tick();
            dsum += int'(done_o) + int'(busy_o);
        end
        check("abort_quiet", dsum, 0);

        // stop beats a simultaneous start in IDLE
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        check("stop_start_busy", int'(busy_o), 0);
        tick();
        check("stop_start_busy_later", int'(busy_o), 0);
        check("stop_start_valid", int'(sel_valid_o), 0);

        // Asynchronous reset while stalled in an offer
        mask_i = 8'hFF; start_i = 1'b1; sel_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (n < 100 && !(sel_valid_o && sel_o == 3'd2)) begin
            tick();
            n++;
        end
        sel_ready_i = 1'b0;
        tick();
        tick();
        check("offer_held_valid", int'(sel_valid_o), 1);
        check("offer_held_sel", int'(sel_o), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", int'(sel_o), 0);
        check("async_rst_valid", int'(sel_valid_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_done", int'(done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sel_ready_i = 1'b1;
        tick();
        run_sweep(8'hFF, 0, 0);
        check_sweep(8'hFF, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
